// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: parses SYNC/ADDR/LEN/payload/CSUM
// frames, verifies the checksum and replays valid payloads as byte writes.
module uart_rx_frame_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_BITS = 20,
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    input  logic       i_wr_ready,
    output logic       o_frame_done,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic       o_busy
);

    localparam int unsigned TIMEOUT_CLKS = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int unsigned TMO_W        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int unsigned IDX_W        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_WRITE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wr_valid_q, wr_valid_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             busy_q, busy_d;

    logic [7:0]       buf_q [MAX_LEN];
    logic             buf_we;
    logic             timed;
    logic [7:0]       sum_add;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        tmo_d        = tmo_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        buf_we       = 1'b0;
        sum_add      = sum_q + i_rx_byte;

        timed = (state_q == S_ADDR) || (state_q == S_LEN) ||
                (state_q == S_PAYLOAD) || (state_q == S_CSUM);

        if (!timed || i_rx_dv) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                idx_d = 8'd0;
                if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (i_rx_dv) begin
                    addr_d  = i_rx_byte;
                    sum_d   = i_rx_byte;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (i_rx_dv) begin
                    len_d = i_rx_byte;
                    sum_d = sum_add;
                    idx_d = 8'd0;
                    if (32'(i_rx_byte) > MAX_LEN) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_IDLE;
                    end else if (i_rx_byte == 8'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_rx_dv) begin
                    buf_we = 1'b1;
                    sum_d  = sum_add;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = S_CSUM;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_CSUM: begin
                if (i_rx_dv) begin
                    idx_d = 8'd0;
                    if (sum_add != 8'd0) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        state_d     = S_IDLE;
                    end else if (len_q == 8'd0) begin
                        frame_done_d = 1'b1;
                        err_code_d   = 2'b00;
                        state_d      = S_DONE;
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = buf_q[IDX_W'(0)];
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // idx_q is the index of the word currently presented
                if (wr_valid_q && i_wr_ready) begin
                    if (idx_q == len_q - 8'd1) begin
                        wr_valid_d   = 1'b0;
                        frame_done_d = 1'b1;
                        err_code_d   = 2'b00;
                        state_d      = S_DONE;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        wr_addr_d = wr_addr_q + 8'd1;
                        wr_data_d = buf_q[IDX_W'(idx_q + 8'd1)];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A byte in the same cycle always beats the timeout
        if (timed && !i_rx_dv && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1))) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = S_IDLE;
            tmo_d       = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= 8'd0;
            len_q        <= 8'd0;
            idx_q        <= 8'd0;
            sum_q        <= 8'd0;
            tmo_q        <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= 8'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            tmo_q        <= tmo_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
        end
    end

    // Payload buffer, contents need no reset
    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            buf_q[IDX_W'(idx_q)] <= i_rx_byte;
        end
    end

    assign o_wr_valid   = wr_valid_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_frame_done = frame_done_q;
    assign o_frame_err  = frame_err_q;
    assign o_err_code   = err_code_q;
    assign o_busy       = busy_q;

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame controller that sits downstream of the UART receiver. It parses its byte stream (one-cycle data-valid strobe plus byte) into framed register-write commands: sync, address, length, payload and checksum. It buffers the payload and checks the frame. Only a valid frame is replayed as a sequence of byte writes over a valid/ready port into the register bank.

## Interface
- CLKS_PER_BIT, 868: bit period in clocks; must match the receiver.
- TIMEOUT_BITS, 20: inter-byte timeout in bit periods; TIMEOUT_CLKS = CLKS_PER_BIT*TIMEOUT_BITS.
- MAX_LEN, 16: payload buffer depth in bytes, range 1..255.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_dv  in  1  one-cycle strobe, byte valid from the receiver.
- i_rx_byte  in  8  received byte, sampled when i_rx_dv=1.
- o_wr_valid  out  1  write command valid.
- o_wr_addr  out  8  write address.
- o_wr_data  out  8  write data.
- i_wr_ready  in  1  sink accepts the write when o_wr_valid and i_wr_ready are both 1.
- o_frame_done  out  1  one-cycle pulse: frame fully written.
- o_frame_err  out  1  one-cycle pulse: frame discarded.
- o_err_code  out  2  01 timeout, 10 LEN>MAX_LEN, 11 checksum; 00 after success; held until the next frame result.
- o_busy  out  1  high in every state except IDLE.

## Operation
- Frame format: SYNC, ADDR, LEN, LEN payload bytes, CSUM.
- A frame is valid iff (ADDR + LEN + payload bytes + CSUM) mod 256 == 0, summed in an 8-bit wrapping accumulator.
- States and transitions:
  - IDLE: non-SYNC bytes are ignored; SYNC -> ADDR.
  - ADDR: latch the base address and load it into the accumulator -> LEN.
  - LEN:
    - LEN > MAX_LEN -> error 10, back to IDLE.
    - LEN == 0 -> CSUM.
    - otherwise -> PAYLOAD.
  - PAYLOAD: store byte[idx] in the buffer, accumulate, idx++; after LEN bytes -> CSUM.
  - CSUM:
    - sum != 0 -> error 11, back to IDLE.
    - LEN == 0 -> DONE.
    - otherwise -> WRITE.
  - WRITE: present buffer[k] at address ADDR+k (8-bit wrap, FF -> 00). Advance k on handshake; the last handshake -> DONE.
  - DONE: pulse o_frame_done, set o_err_code=00 -> IDLE.
- Timeout counter:
  - Clears on every i_rx_dv; counts only in ADDR, LEN, PAYLOAD and CSUM.
  - Reaching TIMEOUT_CLKS-1 -> error 01, back to IDLE.
  - i_rx_dv in the same cycle wins: the byte is accepted and the counter clears.
- Bytes arriving in WRITE or DONE are dropped; the receiver cannot be back-pressured, so the sender must respect o_busy. A SYNC byte inside a frame is treated as data.
- Every error pulses o_frame_err for 1 cycle, updates o_err_code and issues no writes.

## Timing
- Reset values: state IDLE, all counters 0, o_wr_valid 0, o_wr_addr 0, o_wr_data 0, o_frame_done 0, o_frame_err 0, o_err_code 00, o_busy 0. Buffer contents need no reset.
- All outputs are registered. Byte with i_rx_dv at edge T: the resulting state is visible after edge T+1.
- CSUM byte at T, valid frame, LEN>0: o_wr_valid=1 with buffer[0] at ADDR from cycle T+1.
- o_wr_valid, o_wr_addr and o_wr_data stay stable until the handshake. After a handshake the next word appears the next cycle, so 1 write per cycle at full rate.
- Pulse timing:
  - o_frame_done: the cycle after the final handshake, or T+1 for LEN=0.
  - o_frame_err: T+1 after the offending LEN or CSUM byte, or the cycle after the timeout is reached.
- Back-to-back frames: a SYNC byte is accepted in IDLE the cycle after DONE or an error.
- Reset mid-frame or mid-write: the frame is abandoned immediately, all outputs go to reset values, and no done/err pulse is issued.

## Test plan
- Good frame A5 10 03 11 22 33 87, i_wr_ready=1 -> writes (10,11), (11,22), (12,33) on consecutive cycles, then o_frame_done pulse, o_err_code=00.
- Same frame with CSUM 86 -> no o_wr_valid; o_frame_err pulse, o_err_code=11.
- A5 20 11 (LEN 17, MAX_LEN=16) -> o_frame_err the cycle after the LEN byte, code 10. The following good frame is accepted.
- A5 10 then silence (CLKS_PER_BIT=4, TIMEOUT_BITS=20) -> o_frame_err exactly 80 clocks after the last i_rx_dv, code 01, o_busy drops.
- A5 FE 03 AA BB CC CSUM=(-(FE+03+AA+BB+CC)) mod 256, i_wr_ready toggled randomly -> addresses FE, FF, 00, each word held stable while unacknowledged. A zero-length frame A5 40 00 C0 -> done, no writes.
- Assert i_rst_n=0 mid-WRITE -> o_wr_valid=0 asynchronously, no done pulse. After release, a good frame completes normally.
